// File: rtl/freq_scheduler_if.sv
// rtl/freq_scheduler_if.sv - request and physics-side signal bundle for freq_scheduler
interface freq_scheduler_if #(
    parameter int NUM_SLOTS  = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic                 midi_ready;
    logic [6:0]           midi_key;
    logic                 sw_req;
    logic [4:0]           sw_freq;
    logic [NUM_SLOTS-1:0] wave_ready;
    logic [4:0]           freq_id;
    logic [SLOT_W-1:0]    slot;
    logic                 new_freq;
    logic                 busy;
    logic [CNT_W-1:0]     fifo_count;
    logic [7:0]           drop_count;
    logic                 timeout_err;

    modport slave (
        input  midi_ready, midi_key, sw_req, sw_freq, wave_ready,
        output freq_id, slot, new_freq, busy, fifo_count, drop_count, timeout_err
    );

    modport master (
        output midi_ready, midi_key, sw_req, sw_freq, wave_ready,
        input  freq_id, slot, new_freq, busy, fifo_count, drop_count, timeout_err
    );
endinterface

// File: rtl/freq_scheduler.sv
// rtl/freq_scheduler.sv - vsync-aligned frequency request scheduler; FREQ_SCHED_DEDUP_EN enables duplicate suppression
module freq_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int KEY_BASE       = 48,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            vsync,
    freq_scheduler_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FRM_W  = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [7:0]       KEY_BASE_C = 8'(KEY_BASE);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [FRM_W-1:0] LAST_FRM_C = FRM_W'(TIMEOUT_FRAMES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_VS  = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_WAIT_RDY = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              vsync_q;
    logic [4:0]        freq_q, freq_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W-1:0] ptr_q, ptr_d;
    logic              new_freq_q, new_freq_d;
    logic [FRM_W-1:0]  frames_q, frames_d;
    logic              seen_low_q, seen_low_d;
    logic              timeout_q, timeout_d;
    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [4:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              hold_valid_q, hold_valid_d;
    logic [4:0]        hold_f_q, hold_f_d;
    logic [7:0]        drop_q, drop_d;

    logic              vs_rise;
    logic              pop;
    logic              push;
    logic              push_req;
    logic              cand_valid;
    logic [4:0]        cand_f;
    logic [1:0]        drop_inc;
    logic [8:0]        drop_sum;
    logic [7:0]        midi_diff;
    logic              midi_ok;

`ifdef FREQ_SCHED_DEDUP_EN
    logic              last_valid_q, last_valid_d;
    logic [4:0]        last_f_q, last_f_d;
`endif

    assign vs_rise   = vsync & ~vsync_q;
    assign midi_diff = {1'b0, bus.midi_key} - KEY_BASE_C;
    assign midi_ok   = bus.midi_ready && ({1'b0, bus.midi_key} >= KEY_BASE_C) && (midi_diff <= 8'd31);

    // Issue sequencing: wait for a frame edge, pop and issue, then wait for the slot's ready edge or a timeout
    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        new_freq_d = 1'b0;
        frames_d   = frames_q;
        seen_low_d = seen_low_q;
        timeout_d  = timeout_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vs_rise) begin
                    pop     = 1'b1;
                    freq_d  = mem_q[rd_q];
                    slot_d  = ptr_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                new_freq_d = 1'b1;
                ptr_d      = ptr_q + SLOT_W'(1);
                frames_d   = '0;
                seen_low_d = 1'b0;
                state_d    = S_WAIT_RDY;
            end
            default: begin
                // a level still high from the previous use of this slot is ignored until it drops
                if (seen_low_q && bus.wave_ready[slot_q]) begin
                    state_d = S_IDLE;
                end else begin
                    if (!bus.wave_ready[slot_q]) seen_low_d = 1'b1;
                    if (vs_rise) begin
                        if (frames_q == LAST_FRM_C) begin
                            timeout_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            frames_d = frames_q + FRM_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    // Request intake: MIDI wins the write port, a colliding switch request waits in the holding register
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_f_d     = hold_f_q;
        cand_valid   = 1'b0;
        cand_f       = '0;
        drop_inc     = 2'd0;
        mem_d        = mem_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        count_d      = count_q;
`ifdef FREQ_SCHED_DEDUP_EN
        last_valid_d = last_valid_q;
        last_f_d     = last_f_q;
`endif
        if (bus.midi_ready && !midi_ok) drop_inc = drop_inc + 2'd1;
        if (midi_ok) begin
            cand_valid = 1'b1;
            cand_f     = midi_diff[4:0];
            if (bus.sw_req) begin
                if (hold_valid_q) drop_inc = drop_inc + 2'd1;
                hold_valid_d = 1'b1;
                hold_f_d     = bus.sw_freq;
            end
        end else if (hold_valid_q) begin
            cand_valid   = 1'b1;
            cand_f       = hold_f_q;
            hold_valid_d = bus.sw_req;
            if (bus.sw_req) hold_f_d = bus.sw_freq;
        end else if (bus.sw_req) begin
            cand_valid = 1'b1;
            cand_f     = bus.sw_freq;
        end

`ifdef FREQ_SCHED_DEDUP_EN
        // the remembered value lapses once the queue has drained and the scheduler is idle again
        if (state_q == S_IDLE && count_q == '0) last_valid_d = 1'b0;
        push_req = cand_valid && !(last_valid_q && cand_f == last_f_q);
`else
        push_req = cand_valid;
`endif
        push = push_req && ((count_q != DEPTH_C) || pop);
        if (push_req && !push) drop_inc = drop_inc + 2'd1;

        if (push) begin
            mem_d[wr_q] = cand_f;
            wr_d        = wr_q + PTR_W'(1);
`ifdef FREQ_SCHED_DEDUP_EN
            last_valid_d = 1'b1;
            last_f_d     = cand_f;
`endif
        end
        if (pop) rd_d = rd_q + PTR_W'(1);
        if (push && !pop) count_d = count_q + CNT_W'(1);
        if (!push && pop) count_d = count_q - CNT_W'(1);

        drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // State registers; reset aborts any issue in flight and empties the queue
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            freq_q       <= '0;
            slot_q       <= '0;
            ptr_q        <= '0;
            new_freq_q   <= 1'b0;
            frames_q     <= '0;
            seen_low_q   <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_f_q     <= '0;
            drop_q       <= '0;
`ifdef FREQ_SCHED_DEDUP_EN
            last_valid_q <= 1'b0;
            last_f_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            freq_q       <= freq_d;
            slot_q       <= slot_d;
            ptr_q        <= ptr_d;
            new_freq_q   <= new_freq_d;
            frames_q     <= frames_d;
            seen_low_q   <= seen_low_d;
            timeout_q    <= timeout_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_f_q     <= hold_f_d;
            drop_q       <= drop_d;
`ifdef FREQ_SCHED_DEDUP_EN
            last_valid_q <= last_valid_d;
            last_f_q     <= last_f_d;
`endif
        end
    end

    assign bus.freq_id     = freq_q;
    assign bus.slot        = slot_q;
    assign bus.new_freq    = new_freq_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.fifo_count  = count_q;
    assign bus.drop_count  = drop_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_freq_scheduler.sv
// tb/tb_freq_scheduler.sv - scoreboard bench for freq_scheduler
module tb_freq_scheduler;
    localparam int NUM_SLOTS  = 4;
    localparam int FIFO_DEPTH = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic vsync   = 1'b0;

    freq_scheduler_if #(.NUM_SLOTS(NUM_SLOTS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    freq_scheduler #(
        .NUM_SLOTS(NUM_SLOTS), .FIFO_DEPTH(FIFO_DEPTH), .KEY_BASE(48), .TIMEOUT_FRAMES(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .vsync(vsync), .bus(bus)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] exp_q[$];
    int         exp_drop;
    logic [1:0] exp_ptr;
    logic [4:0] want_f;
    bit         early, seen, nf_after, busy_before, busy_after;
    logic [4:0] got_f;
    logic [1:0] got_s;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        vsync = 1'b0;
        bus.midi_ready = 1'b0; bus.midi_key = '0; bus.sw_req = 1'b0; bus.sw_freq = '0; bus.wave_ready = '0;
        exp_q.delete(); exp_drop = 0; exp_ptr = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic midi_req(input int key);
        bus.midi_ready = 1'b1; bus.midi_key = 7'(key);
        tick();
        bus.midi_ready = 1'b0;
        if (key < 48 || key - 48 > 31) exp_drop++;
        else if (exp_q.size() >= FIFO_DEPTH) exp_drop++;
        else exp_q.push_back(5'(key - 48));
    endtask

    task automatic issue_frame(input bit also_midi, input int key, output bit e, output bit s_nf,
                               output logic [4:0] f, output logic [1:0] s);
        tick();
        vsync = 1'b1;
        if (also_midi) begin bus.midi_ready = 1'b1; bus.midi_key = 7'(key); end
        tick();
        e = bus.new_freq;
        vsync = 1'b0; bus.midi_ready = 1'b0;
        tick();
        s_nf = bus.new_freq; f = bus.freq_id; s = bus.slot;
    endtask

    task automatic handshake(input logic [1:0] s, output bit nf, output bit b0, output bit b1);
        bus.wave_ready[s] = 1'b0;
        tick();
        nf = bus.new_freq; b0 = bus.busy;
        bus.wave_ready[s] = 1'b1;
        tick();
        b1 = bus.busy;
        bus.wave_ready = '0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.freq_id !== 5'd0) begin n_err++; $display("FAIL rst_freq: got %0d want 0", bus.freq_id); end
        n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL rst_slot: got %0d want 0", bus.slot); end
        n_cmp++; if (bus.new_freq !== 1'b0) begin n_err++; $display("FAIL rst_new: got %0d want 0", bus.new_freq); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d want 0", bus.busy); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", bus.drop_count); end
        n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_tmo: got %0d want 0", bus.timeout_err); end
    endtask

    task automatic test_single_issue();
        do_reset();
        midi_req(60);
        issue_frame(1'b0, 0, early, seen, got_f, got_s);
        want_f = exp_q.pop_front();
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL t1_early: got %0d want 0", early); end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL t1_new: got %0d want 1", seen); end
        n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL t1_freq: got %0d want %0d", got_f, want_f); end
        n_cmp++; if (got_s !== exp_ptr) begin n_err++; $display("FAIL t1_slot: got %0d want %0d", got_s, exp_ptr); end
        exp_ptr++;
        handshake(got_s, nf_after, busy_before, busy_after);
        n_cmp++; if (nf_after !== 1'b0) begin n_err++; $display("FAIL t1_pulse: got %0d want 0", nf_after); end
        n_cmp++; if (busy_before !== 1'b1) begin n_err++; $display("FAIL t1_busy_wait: got %0d want 1", busy_before); end
        n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL t1_busy_done: got %0d want 0", busy_after); end
        n_cmp++; if (bus.freq_id !== 5'd12) begin n_err++; $display("FAIL t1_hold: got %0d want 12", bus.freq_id); end
    endtask

    task automatic test_fill_and_drain();
        do_reset();
        for (int k = 48; k <= 52; k++) midi_req(k);
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL t2_count: got %0d want 4", bus.fifo_count); end
        n_cmp++; if (bus.drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL t2_drop: got %0d want %0d", bus.drop_count, exp_drop); end
        for (int i = 0; i < 4; i++) begin
            issue_frame(1'b0, 0, early, seen, got_f, got_s);
            want_f = exp_q.pop_front();
            n_cmp++; if (early !== 1'b0 || seen !== 1'b1) begin n_err++; $display("FAIL t2_timing%0d: got %0d%0d want 01", i, early, seen); end
            n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL t2_freq%0d: got %0d want %0d", i, got_f, want_f); end
            n_cmp++; if (got_s !== exp_ptr) begin n_err++; $display("FAIL t2_slot%0d: got %0d want %0d", i, got_s, exp_ptr); end
            exp_ptr++;
            handshake(got_s, nf_after, busy_before, busy_after);
            repeat (3) tick();
            n_cmp++; if (bus.fifo_count !== 3'(exp_q.size())) begin n_err++; $display("FAIL t2_one_per_frame%0d: got %0d want %0d", i, bus.fifo_count, exp_q.size()); end
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.midi_ready = 1'b1; bus.midi_key = 7'd50; bus.sw_req = 1'b1; bus.sw_freq = 5'd7;
        tick();
        bus.midi_ready = 1'b0; bus.sw_req = 1'b0;
        exp_q.push_back(5'd2); exp_q.push_back(5'd7);
        tick();
        n_cmp++; if (bus.fifo_count !== 3'd2) begin n_err++; $display("FAIL t3_count: got %0d want 2", bus.fifo_count); end
        n_cmp++; if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL t3_drop: got %0d want 0", bus.drop_count); end
        for (int i = 0; i < 2; i++) begin
            issue_frame(1'b0, 0, early, seen, got_f, got_s);
            want_f = exp_q.pop_front();
            n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL t3_freq%0d: got %0d want %0d", i, got_f, want_f); end
            handshake(got_s, nf_after, busy_before, busy_after);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.midi_ready = 1'b1; bus.midi_key = 7'd50; bus.sw_req = 1'b1; bus.sw_freq = 5'd7;
        tick();
        bus.midi_key = 7'd51; bus.sw_freq = 5'd9;
        tick();
        bus.midi_ready = 1'b0; bus.sw_req = 1'b0;
        tick();
        exp_q.push_back(5'd2); exp_q.push_back(5'd3); exp_q.push_back(5'd9);
        n_cmp++; if (bus.fifo_count !== 3'd3) begin n_err++; $display("FAIL bb_count: got %0d want 3", bus.fifo_count); end
        n_cmp++; if (bus.drop_count !== 8'd1) begin n_err++; $display("FAIL bb_drop: got %0d want 1", bus.drop_count); end
        for (int i = 0; i < 3; i++) begin
            issue_frame(1'b0, 0, early, seen, got_f, got_s);
            want_f = exp_q.pop_front();
            n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL bb_freq%0d: got %0d want %0d", i, got_f, want_f); end
            handshake(got_s, nf_after, busy_before, busy_after);
        end
    endtask

    task automatic test_range();
        do_reset();
        midi_req(47);
        midi_req(80);
        n_cmp++; if (bus.drop_count !== 8'd2) begin n_err++; $display("FAIL t4_drop: got %0d want 2", bus.drop_count); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL t4_count: got %0d want 0", bus.fifo_count); end
        midi_req(79);
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL t4_edge_count: got %0d want 1", bus.fifo_count); end
        issue_frame(1'b0, 0, early, seen, got_f, got_s);
        want_f = exp_q.pop_front();
        n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL t4_edge_freq: got %0d want %0d", got_f, want_f); end
        handshake(got_s, nf_after, busy_before, busy_after);
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int k = 48; k <= 51; k++) midi_req(k);
        issue_frame(1'b1, 60, early, seen, got_f, got_s);
        exp_q.push_back(5'd12);
        want_f = exp_q.pop_front();
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL pp_count: got %0d want 4", bus.fifo_count); end
        n_cmp++; if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL pp_drop: got %0d want 0", bus.drop_count); end
        n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL pp_freq: got %0d want %0d", got_f, want_f); end
        handshake(got_s, nf_after, busy_before, busy_after);
        for (int i = 0; i < 4; i++) begin
            issue_frame(1'b0, 0, early, seen, got_f, got_s);
            want_f = exp_q.pop_front();
            n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL pp_drain%0d: got %0d want %0d", i, got_f, want_f); end
            handshake(got_s, nf_after, busy_before, busy_after);
        end
    endtask

    task automatic test_stale_ready();
        do_reset();
        bus.wave_ready[0] = 1'b1;
        midi_req(55);
        issue_frame(1'b0, 0, early, seen, got_f, got_s);
        want_f = exp_q.pop_front();
        n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL st_freq: got %0d want %0d", got_f, want_f); end
        repeat (3) tick();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL st_stale: got %0d want 1", bus.busy); end
        bus.wave_ready[0] = 1'b0;
        tick();
        bus.wave_ready[0] = 1'b1;
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL st_done: got %0d want 0", bus.busy); end
        bus.wave_ready = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        midi_req(60);
        issue_frame(1'b0, 0, early, seen, got_f, got_s);
        void'(exp_q.pop_front());
        n_cmp++; if (got_s !== exp_ptr) begin n_err++; $display("FAIL t5_slot: got %0d want %0d", got_s, exp_ptr); end
        exp_ptr++;
        for (int i = 0; i < 3; i++) begin
            vsync = 1'b1; tick(); vsync = 1'b0; tick();
        end
        n_cmp++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL t5_early: got busy %0d tmo %0d want 1 0", bus.busy, bus.timeout_err); end
        vsync = 1'b1; tick(); vsync = 1'b0;
        n_cmp++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL t5_tmo: got %0d want 1", bus.timeout_err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL t5_idle: got %0d want 0", bus.busy); end
        midi_req(61);
        issue_frame(1'b0, 0, early, seen, got_f, got_s);
        want_f = exp_q.pop_front();
        n_cmp++; if (got_f !== want_f) begin n_err++; $display("FAIL t5_next_freq: got %0d want %0d", got_f, want_f); end
        n_cmp++; if (got_s !== exp_ptr) begin n_err++; $display("FAIL t5_next_slot: got %0d want %0d", got_s, exp_ptr); end
        handshake(got_s, nf_after, busy_before, busy_after);
        n_cmp++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL t5_sticky: got %0d want 1", bus.timeout_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 50; k <= 54; k++) midi_req(k);
        issue_frame(1'b0, 0, early, seen, got_f, got_s);
        n_cmp++; if (bus.fifo_count !== 3'd3 || bus.busy !== 1'b1) begin n_err++; $display("FAIL t6_pre: got count %0d busy %0d want 3 1", bus.fifo_count, bus.busy); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL t6_count: got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.new_freq !== 1'b0) begin n_err++; $display("FAIL t6_new: got %0d want 0", bus.new_freq); end
        n_cmp++; if (bus.freq_id !== 5'd0) begin n_err++; $display("FAIL t6_freq: got %0d want 0", bus.freq_id); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL t6_busy: got %0d want 0", bus.busy); end
        n_cmp++; if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL t6_drop: got %0d want 0", bus.drop_count); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_drop_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) midi_req(10);
        n_cmp++; if (bus.drop_count !== 8'd255) begin n_err++; $display("FAIL sat_drop: got %0d want 255 (model %0d)", bus.drop_count, exp_drop); end
    endtask

    task automatic test_dedup();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.sw_req = 1'b1; bus.sw_freq = 5'd5; tick(); bus.sw_req = 1'b0; tick();
        end
`ifdef FREQ_SCHED_DEDUP_EN
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL t7_count: got %0d want 1", bus.fifo_count); end
`else
        n_cmp++; if (bus.fifo_count !== 3'd2) begin n_err++; $display("FAIL t7_count: got %0d want 2", bus.fifo_count); end
`endif
        n_cmp++; if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL t7_drop: got %0d want 0", bus.drop_count); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_issue();
        test_fill_and_drain();
        test_collision();
        test_back_to_back();
        test_range();
        test_push_pop_full();
        test_stale_ready();
        test_timeout();
        test_async_reset();
        test_drop_saturate();
        test_dedup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
